// File: rtl/branch_pht_if.sv
// Prediction/update bundle between the pipeline datapath and the branch PHT.
interface branch_pht_if;
  logic [31:0] pcF;
  logic        branchM;
  logic [31:0] pcM;
  logic        takenM;
  logic        predM;
  logic        pbranchF;
  logic        pmis;
  logic        flushD;
  logic        flushE;
  logic        flushM;
  logic [31:0] br_cnt;
  logic [31:0] mis_cnt;

  modport master (
    output pcF, branchM, pcM, takenM, predM,
    input  pbranchF, pmis, flushD, flushE, flushM, br_cnt, mis_cnt
  );

  modport slave (
    input  pcF, branchM, pcM, takenM, predM,
    output pbranchF, pmis, flushD, flushE, flushM, br_cnt, mis_cnt
  );
endinterface

// File: rtl/branch_pht_unit.sv
// Bimodal branch predictor: table of 2-bit saturating counters indexed by PC,
// read in fetch and trained in memory stage, with misprediction statistics.
module branch_pht_unit #(
  parameter int         IDX_W    = 6,
  parameter logic [1:0] INIT_CNT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  branch_pht_if.slave bus
);
  localparam int ENTRIES = 1 << IDX_W;

  function automatic logic [1:0] sat_step2(input logic [1:0] cnt, input logic up);
    if (up) return (cnt == 2'b11) ? cnt : cnt + 2'b01;
    else     return (cnt == 2'b00) ? cnt : cnt - 2'b01;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] val, input logic en);
    return (en && (val != 32'hFFFF_FFFF)) ? val + 32'd1 : val;
  endfunction

  logic [1:0]       pht_q [ENTRIES];
  logic [1:0]       upd_cnt_d;
  logic [IDX_W-1:0] idx_f;
  logic [IDX_W-1:0] idx_m;
  logic             mis;
  logic [31:0]      br_cnt_q;
  logic [31:0]      br_cnt_d;
  logic [31:0]      mis_cnt_q;
  logic [31:0]      mis_cnt_d;
  logic             unused_pc_bits;

  assign idx_f = bus.pcF[IDX_W+1:2];
  assign idx_m = bus.pcM[IDX_W+1:2];
  assign unused_pc_bits = ^{bus.pcF[31:IDX_W+2], bus.pcF[1:0],
                            bus.pcM[31:IDX_W+2], bus.pcM[1:0]};

  // Prediction reads the registered table directly, so a same-cycle update is not bypassed.
  assign bus.pbranchF = pht_q[idx_f][1];

  assign mis         = bus.branchM & (bus.takenM != bus.predM);
  assign bus.pmis    = mis;
  assign bus.flushD  = mis;
  assign bus.flushE  = mis;
  assign bus.flushM  = mis;

  assign upd_cnt_d = sat_step2(pht_q[idx_m], bus.takenM);
  assign br_cnt_d  = sat_inc32(br_cnt_q, bus.branchM);
  assign mis_cnt_d = sat_inc32(mis_cnt_q, mis);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) pht_q[i] <= INIT_CNT;
    end else if (bus.branchM) begin
      pht_q[idx_m] <= upd_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign bus.br_cnt  = br_cnt_q;
  assign bus.mis_cnt = mis_cnt_q;
endmodule

// File: doc/branch_pht_unit.md
BRANCH_PHT_UNIT -- requirements
Module: branch_pht_unit

Interface
REQ-001 Parameter IDX_W, default 6, PHT index width; the table has 2^IDX_W entries.
REQ-002 Parameter INIT_CNT, default 2'b01, per-entry counter value after reset (weakly not-taken).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low; asserted (0) clears all state immediately.
REQ-005 pcF  in  32  fetch-stage PC to predict.
REQ-006 branchM  in  1  memory-stage instruction is a conditional branch.
REQ-007 pcM  in  32  memory-stage branch PC.
REQ-008 takenM  in  1  resolved branch direction (1 = taken).
REQ-009 predM  in  1  direction predicted for that branch, carried down the pipeline.
REQ-010 pbranchF  out  1  predicted direction for pcF.
REQ-011 pmis  out  1  memory-stage branch mispredicted; selects the recovery PC in the datapath.
REQ-012 flushD, flushE, flushM  out  1 each  clear the F->D, D->E and E->M pipeline registers.
REQ-013 br_cnt  out  32  resolved branches since reset.
REQ-014 mis_cnt  out  32  mispredictions since reset.

Function
REQ-015 Index = pc[IDX_W+1:2]; pcF forms the prediction index and pcM the update index; pc[1:0] is ignored.
REQ-016 Each entry is a 2-bit saturating counter; pbranchF = counter[1] of entry idx(pcF), combinational, zero-cycle latency.
REQ-017 pmis = branchM & (takenM != predM), combinational.
REQ-018 flushD = flushE = flushM = pmis; no other source asserts them.
REQ-019 On each rising edge with branchM=1, entry idx(pcM) increments toward 3 if takenM=1, else decrements toward 0.
REQ-020 Saturation: 3 + taken stays 3; 0 + not-taken stays 0; no wrap-around.
REQ-021 With branchM=0 the table is unchanged regardless of takenM, predM and pcM.
REQ-022 Same-cycle read/write of one index: pbranchF reflects the pre-update value; no bypass; the new value is visible next cycle.
REQ-023 br_cnt increments by 1 per edge with branchM=1; mis_cnt increments by 1 per edge with pmis=1.
REQ-024 Both counters saturate at 32'hFFFF_FFFF and never wrap.
REQ-025 predM is trusted as given; the block stores no per-branch pipeline state; a repeated pcM updates the same entry again.
REQ-026 Update is unconditional on stall: the datapath presents branchM for exactly one cycle per retired branch.

Reset
REQ-027 While rst=0, every PHT entry = INIT_CNT, br_cnt = mis_cnt = 0, and the table and counters ignore clk.
REQ-028 Outputs under reset: pbranchF = INIT_CNT[1] (0 by default); pmis and the flushes follow their combinational inputs.
REQ-029 Reset asserted mid-training discards all history; the first prediction after release equals INIT_CNT[1].
REQ-030 Release of rst is synchronised by the integrator; the block needs no release sequencing.

Verification
REQ-031 After reset, pcF=0x00400010 -> pbranchF=0; br_cnt=0; mis_cnt=0.
REQ-032 Two edges with branchM=1, pcM=0x00400010, takenM=1, predM=0 -> pmis=1 and all flushes=1 during each update cycle; then pcF=0x00400010 -> pbranchF=1; mis_cnt=2; br_cnt=2.
REQ-033 Saturation: five taken updates on one PC, then one not-taken -> counter 3 then 2; pbranchF stays 1; a second not-taken -> pbranchF=0.
REQ-034 Aliasing: train pcM=0x00000104 taken twice -> pcF=0x00000004 and pcF=0x00000104 both give pbranchF=1 (IDX_W=6).
REQ-035 Same-cycle case: pcF=pcM with entry at 1, taken update -> pbranchF=0 in that cycle and 1 in the next cycle.
REQ-036 Assert rst mid-sequence after training to 3 -> counters read 0 immediately and pbranchF=0 with no clock edge; branchM=1 while rst=0 -> no change.
